// File: rtl/timer_cmp_ctrl_if.sv
// rtl/timer_cmp_ctrl_if.sv - register write strobe and dual tri-state read bus for timer_cmp_ctrl
interface timer_cmp_ctrl_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_A_en;
  logic [1:0]  rd_A_addr;
  wire  [31:0] data_A_out;
  logic        rd_B_en;
  logic [1:0]  rd_B_addr;
  wire  [31:0] data_B_out;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_A_en, rd_A_addr, rd_B_en, rd_B_addr,
    input  data_A_out, data_B_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_A_en, rd_A_addr, rd_B_en, rd_B_addr,
    output data_A_out, data_B_out
  );
endinterface

// File: rtl/timer_cmp_ctrl.sv
// rtl/timer_cmp_ctrl.sv - compare/interrupt scheduler for the free-running ms timer
module timer_cmp_ctrl #(
  parameter logic [31:0] PERIOD_DEF = 32'd0,
  parameter int          OVR_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            time_in,
  timer_cmp_ctrl_if.slave        bus,
  output logic                   irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_CMP    = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;
  localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};

  state_t             state, state_nxt;
  logic               ctrl_en, ctrl_periodic, ctrl_irq_en;
  logic [31:0]        cmp, period;
  logic               pending, pending_nxt;
  logic [OVR_W-1:0]   ovr, ovr_nxt;

  logic               wr_ctrl, wr_cmp, wr_period, wr_status, reg_wr;
  logic               clr_pending, clr_ovr, irq_en_nxt;
  logic [31:0]        cmp_diff;
  logic               hit, reload;
  logic [31:0]        ctrl_rd, status_rd, rd_a, rd_b;

  assign wr_ctrl   = bus.wr_en && (bus.wr_addr == A_CTRL);
  assign wr_cmp    = bus.wr_en && (bus.wr_addr == A_CMP);
  assign wr_period = bus.wr_en && (bus.wr_addr == A_PERIOD);
  assign wr_status = bus.wr_en && (bus.wr_addr == A_STATUS);
  assign reg_wr    = wr_ctrl || wr_cmp || wr_period;

  // Wrap-safe: a target up to 2^31-1 behind the current time counts as reached.
  assign cmp_diff = time_in - cmp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (wr_ctrl) begin
      state_nxt = bus.wr_data[0] ? ARMED : IDLE;
    end else if (wr_cmp && (state == DONE) && ctrl_en) begin
      state_nxt = ARMED;
    end else if (hit && !reload) begin
      state_nxt = DONE;
    end
  end

  always_comb begin
    hit         = (state == ARMED) && !reg_wr && !cmp_diff[31];
    reload      = hit && ctrl_periodic && (period != 32'd0);
    clr_pending = wr_status && bus.wr_data[0];
    clr_ovr     = wr_status && bus.wr_data[1];
    irq_en_nxt  = wr_ctrl ? bus.wr_data[2] : ctrl_irq_en;

    // A new event always wins over a same-cycle acknowledge.
    pending_nxt = pending;
    if (clr_pending) pending_nxt = 1'b0;
    if (hit)         pending_nxt = 1'b1;

    ovr_nxt = ovr;
    if (clr_ovr) ovr_nxt = '0;
    if (hit && pending) begin
      if (clr_ovr) begin
        ovr_nxt    = '0;
        ovr_nxt[0] = 1'b1;
      end else if (ovr != OVR_MAX) begin
        ovr_nxt = ovr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      cmp           <= 32'd0;
      period        <= PERIOD_DEF;
      pending       <= 1'b0;
      ovr           <= '0;
      irq           <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en       <= bus.wr_data[0];
        ctrl_periodic <= bus.wr_data[1];
        ctrl_irq_en   <= bus.wr_data[2];
      end
      if (wr_cmp) begin
        cmp <= bus.wr_data;
      end else if (reload) begin
        cmp <= cmp + period;
      end
      if (wr_period) begin
        period <= bus.wr_data;
      end
      pending <= pending_nxt;
      ovr     <= ovr_nxt;
      irq     <= pending_nxt && irq_en_nxt;
    end
  end

  always_comb begin
    ctrl_rd             = 32'd0;
    ctrl_rd[2:0]        = {ctrl_irq_en, ctrl_periodic, ctrl_en};
    status_rd           = 32'd0;
    status_rd[0]        = pending;
    status_rd[1]        = (state == ARMED);
    status_rd[8 +: OVR_W] = ovr;
  end

  always_comb begin
    case (bus.rd_A_addr)
      A_CTRL:   rd_a = ctrl_rd;
      A_CMP:    rd_a = cmp;
      A_PERIOD: rd_a = period;
      default:  rd_a = status_rd;
    endcase
    case (bus.rd_B_addr)
      A_CTRL:   rd_b = ctrl_rd;
      A_CMP:    rd_b = cmp;
      A_PERIOD: rd_b = period;
      default:  rd_b = status_rd;
    endcase
  end

  assign bus.data_A_out = bus.rd_A_en ? rd_a : 32'bz;
  assign bus.data_B_out = bus.rd_B_en ? rd_b : 32'bz;

endmodule

// File: tb/tb_timer_cmp_ctrl.sv
// tb/tb_timer_cmp_ctrl.sv - directed and randomized checks of timer_cmp_ctrl against a reference model
module tb_timer_cmp_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_DONE  = 2;
  localparam int OVR_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] time_in = 32'd0;
  logic        irq;

  timer_cmp_ctrl_if bus ();

  timer_cmp_ctrl #(.PERIOD_DEF(32'd0), .OVR_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .time_in (time_in),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] tm = 32'd0;

  // reference model: register contents and scheduler mode
  logic [2:0]  m_ctrl;
  logic [31:0] m_cmp, m_period;
  bit          m_pend;
  int          m_ovr;
  int          m_st;

  bit          last_pend = 1'b0;
  logic [31:0] dq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'd0, 8'(m_ovr), 6'd0, (m_st == S_ARMED), m_pend};
  endfunction

  function automatic logic [31:0] m_reg(input int a);
    case (a)
      0:       return {29'd0, m_ctrl};
      1:       return m_cmp;
      2:       return m_period;
      default: return m_status();
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 3'd0; m_cmp = 32'd0; m_period = 32'd0;
    m_pend = 1'b0; m_ovr = 0; m_st = S_IDLE;
  endtask

  // One clock: drive a (possibly empty) write with time_in=tm, advance the model, check irq and STATUS.
  task automatic tick(input bit we, input logic [1:0] wa, input logic [31:0] wd);
    bit hit, was_pend, is_stat, is_reg;
    logic [31:0] st;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; time_in = tm;
    is_stat = we && (wa == 2'd3);
    is_reg  = we && (wa != 2'd3);
    hit = (m_st == S_ARMED) && !is_reg && ($signed(tm - m_cmp) >= 0);
    if (!rst_n) begin
      model_reset();
    end else begin
      was_pend = m_pend;
      if (is_stat && wd[0]) m_pend = 1'b0;
      if (is_stat && wd[1]) m_ovr = 0;
      if (hit) begin
        m_pend = 1'b1;
        if (was_pend) m_ovr = (m_ovr < OVR_MAX) ? m_ovr + 1 : OVR_MAX;
      end
      if (we && wa == 2'd0) begin
        m_ctrl = wd[2:0];
        m_st = wd[0] ? S_ARMED : S_IDLE;
      end else if (we && wa == 2'd1 && m_st == S_DONE && m_ctrl[0]) begin
        m_st = S_ARMED;
      end
      if (we && wa == 2'd1) m_cmp = wd;
      if (we && wa == 2'd2) m_period = wd;
      if (hit) begin
        if (m_ctrl[1] && m_period != 0) m_cmp = m_cmp + m_period;
        else m_st = S_DONE;
      end
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_A_en = 1'b0;
    bus.rd_B_en = 1'b1; bus.rd_B_addr = 2'd3;
    #1;
    st = bus.data_B_out;
    chk("irq", {31'd0, irq}, {31'd0, m_pend && m_ctrl[2]});
    chk("status", st, m_status());
    if (st[0] && !last_pend) dq.push_back(tm);
    last_pend = st[0];
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.rd_A_en = 1'b1; bus.rd_A_addr = a;
    #1;
    d = bus.data_A_out;
    bus.rd_A_en = 1'b0;
  endtask

  task automatic check_all();
    for (int a = 0; a < 4; a++) begin
      bus.rd_A_en = 1'b1; bus.rd_A_addr = 2'(a);
      bus.rd_B_en = 1'b1; bus.rd_B_addr = 2'(a);
      #1;
      chk($sformatf("reg_a%0d", a), bus.data_A_out, m_reg(a));
      chk($sformatf("reg_b%0d", a), bus.data_B_out, m_reg(a));
    end
    bus.rd_A_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] zz;
    int r;
    logic [1:0] wa;
    logic [31:0] wd;
    zz = 32'bz;
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 32'd0;
    bus.rd_A_en = 1'b0; bus.rd_A_addr = 2'd0;
    bus.rd_B_en = 1'b0; bus.rd_B_addr = 2'd0;
    model_reset();

    // reset state
    rst_n = 1'b0;
    tick(0, 0, 0); tick(0, 0, 0);
    rst_n = 1'b1;
    tick(0, 0, 0);
    check_all();
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // one-shot
    tm = 32'd95;
    tick(1, 1, 32'd100);
    tick(1, 0, 32'h5);
    for (int t = 95; t <= 110; t++) begin
      tm = 32'(t);
      tick(0, 0, 0);
      if (t == 99)  chk("t1_irq_before", {31'd0, irq}, 32'd0);
      if (t == 100) begin
        chk("t1_irq_at", {31'd0, irq}, 32'd1);
        rd(2'd3, d);
        chk("t1_status", d, 32'h1);
      end
    end
    tick(1, 3, 32'h1);
    chk("t1_ack_irq", {31'd0, irq}, 32'd0);
    tm = tm + 1; tick(0, 0, 0);
    tm = tm + 1; tick(0, 0, 0);
    chk("t1_no_more", {31'd0, irq}, 32'd0);

    // periodic with ack
    tm = 32'd5;
    tick(1, 0, 32'h0);
    tick(1, 2, 32'd5);
    tick(1, 1, 32'd10);
    tick(1, 0, 32'h7);
    dq.delete();
    for (int t = 6; t <= 27; t++) begin
      tm = 32'(t);
      if (m_pend) tick(1, 3, 32'h1);
      else        tick(0, 0, 0);
    end
    chk("t2_nevents", 32'(dq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < dq.size()) chk($sformatf("t2_ev%0d", i), dq[i], 32'(10 + 5 * i));
    end
    rd(2'd1, d);
    chk("t2_cmp", d, 32'd30);

    // overrun saturation
    tick(1, 0, 32'h0);
    tick(1, 3, 32'h3);
    tick(1, 2, 32'd1);
    tick(1, 1, tm);
    tick(1, 0, 32'h3);
    for (int i = 0; i < 300; i++) begin
      tm = tm + 1; tick(0, 0, 0);
    end
    rd(2'd3, d);
    chk("t3_sat", d, 32'h0000_FF03);
    tm = tm + 1; tick(1, 3, 32'h2);
    rd(2'd3, d);
    chk("t3_clr_collide", d, 32'h0000_0103);
    tick(1, 0, 32'h0);
    tick(1, 3, 32'h2);
    rd(2'd3, d);
    chk("t3_clr", d, 32'h1);

    // wrap-around
    tick(1, 3, 32'h3);
    tm = 32'hFFFF_FFFE;
    tick(1, 1, 32'd2);
    tick(1, 0, 32'h5);
    for (int i = 0; i < 4; i++) begin
      tm = 32'hFFFF_FFFE + 32'(i);
      tick(0, 0, 0);
    end
    chk("t4_no_wrap_ev", {31'd0, irq}, 32'd0);
    tm = 32'd2; tick(0, 0, 0);
    chk("t4_ev_at2", {31'd0, irq}, 32'd1);
    tick(1, 3, 32'h1);
    tm = 32'h8000_0000;
    tick(0, 0, 0);
    tick(1, 1, 32'h7FFF_FFF0);
    chk("t4_cmpwr_noev", {31'd0, irq}, 32'd0);
    tick(0, 0, 0);
    chk("t4_past_ev", {31'd0, irq}, 32'd1);

    // collisions
    tick(1, 0, 32'h0);
    tick(1, 3, 32'h3);
    tm = 32'd50;
    tick(1, 2, 32'd3);
    tick(1, 1, 32'd52);
    tick(1, 0, 32'h7);
    tm = 32'd51; tick(0, 0, 0);
    tm = 32'd52; tick(0, 0, 0);
    tm = 32'd53; tick(0, 0, 0);
    tm = 32'd54; tick(0, 0, 0);
    tm = 32'd55; tick(1, 3, 32'h1);
    rd(2'd3, d);
    chk("t5_w1c_collide", d, 32'h0000_0103);
    tm = 32'd56; tick(1, 3, 32'h3);
    tm = 32'd59; tick(1, 1, 32'd60);
    tm = 32'd60; tick(1, 1, 32'd60);
    chk("t5_cmpwr_suppress", {31'd0, irq}, 32'd0);
    tm = 32'd61; tick(0, 0, 0);
    chk("t5_after_suppress", {31'd0, irq}, 32'd1);
    bus.rd_A_en = 1'b1; bus.rd_A_addr = 2'd3;
    bus.rd_B_en = 1'b1; bus.rd_B_addr = 2'd3;
    #1;
    chk("t5_dual_rd", bus.data_A_out, bus.data_B_out);
    chk("t5_dual_model", bus.data_A_out, m_status());
    bus.rd_A_en = 1'b0; bus.rd_B_en = 1'b0; bus.rd_A_addr = 2'd1; bus.rd_B_addr = 2'd1;
    #1;
    chk("t5_A_z", bus.data_A_out, zz);
    chk("t5_B_z", bus.data_B_out, zz);

    // reset mid-operation
    tick(1, 0, 32'h0);
    tick(1, 3, 32'h3);
    tick(1, 2, 32'd1);
    tick(1, 1, tm);
    tick(1, 0, 32'h7);
    for (int i = 0; i < 4; i++) begin
      tm = tm + 1; tick(0, 0, 0);
    end
    rd(2'd3, d);
    chk("t6_pre", d, 32'h0000_0303);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tm = tm + 1; tick(0, 0, 0);
    rd(2'd3, d);
    chk("t6_async_ignored", d, 32'h0000_0403);
    rst_n = 1'b0;
    tm = tm + 1; tick(1, 1, 32'h1234);
    rst_n = 1'b1;
    check_all();
    chk("t6_irq", {31'd0, irq}, 32'd0);
    rd(2'd1, d);
    chk("t6_cmp", d, 32'd0);
    rd(2'd3, d);
    chk("t6_status", d, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      tm = tm + 32'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        wa = 2'($urandom_range(0, 3));
        case (wa)
          2'd0:    wd = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
          2'd1:    wd = tm + 32'($urandom_range(0, 8)) - 32'd3;
          2'd2:    wd = 32'($urandom_range(0, 3));
          default: wd = 32'($urandom_range(0, 3));
        endcase
        tick(1'b1, wa, wd);
      end else begin
        tick(0, 0, 0);
      end
      if (i % 50 == 49) check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_cmp_ctrl.md
Name: timer_cmp_ctrl

Overview:
Compare/interrupt scheduler for the free-running millisecond timer. It watches the timer's 32-bit ms count and raises an interrupt when the count reaches a programmed compare value, either once or periodically with automatic reload. It sits beside the timer on the CPU register bus: registers are written through a simple write strobe and read through the A/B tri-state read ports. It also counts missed (overrun) events.

Parameters:
PERIOD_DEF, 32'd0, reset value of the PERIOD register.
OVR_W, 8, width of the saturating overrun counter (1..16).

Ports:
clk  in  1  system clock.
rst_n  in  1  active-low reset, synchronous to clk.
time_in  in  32  ms count from the timer; increments by at most 1 per cycle and wraps 2^32-1 -> 0.
wr_en  in  1  register write strobe, one cycle per write.
wr_addr  in  2  write register select: 0 CTRL, 1 CMP, 2 PERIOD, 3 STATUS.
wr_data  in  32  write data.
rd_A_en  in  1  read enable, bus A.
rd_A_addr  in  2  read select, bus A.
data_A_out  out  32  register read data when rd_A_en=1, else 32'bz.
rd_B_en  in  1  read enable, bus B.
rd_B_addr  in  2  read select, bus B.
data_B_out  out  32  register read data when rd_B_en=1, else 32'bz.
irq  out  1  level interrupt = pending & CTRL.irq_en.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is synchronous and active-low and is sampled only on posedge clk.
- Reset values: CTRL=0, CMP=0, PERIOD=PERIOD_DEF, pending=0, ovr=0, state=IDLE, irq=0.
- Registers:
  - CTRL: bit0 en, bit1 periodic, bit2 irq_en. Other bits read 0.
  - CMP: 32-bit target.
  - PERIOD: 32-bit reload interval.
  - STATUS (read): bit0 pending, bit1 armed (state==ARMED), bits[8+OVR_W-1:8] ovr, all other bits 0.
  - STATUS (write): writing 1 to bit0 clears pending; writing 1 to bit1 clears ovr. Writing 0 has no effect.
- Reads are combinational: data_x_out = rd_x_en ? reg[rd_x_addr] : 32'bz. Both buses may read at once, including the same address.
- Match: hit = (state==ARMED) && ((time_in - CMP) bit31 == 0). This is a wrap-safe signed difference, so a CMP already up to 2^31-1 in the past fires immediately.
- FSM states: IDLE, ARMED, DONE.
  - Any state: a CTRL write with en=0 goes to IDLE. pending and ovr are kept.
  - IDLE: a CTRL write with en=1 goes to ARMED on the next cycle.
  - ARMED, on hit:
    - If periodic=1 and PERIOD!=0: CMP <= CMP + PERIOD (mod 2^32) and stay ARMED.
    - Otherwise: go to DONE.
  - DONE: a CMP write while en=1 goes to ARMED. A CTRL write with en=1 also re-arms.
- Event on hit:
  - If pending=0: pending <= 1.
  - If pending is already 1: ovr <= ovr+1, saturating at 2^OVR_W-1. pending stays 1.
- Latency: pending and irq rise on the clk edge at which hit is sampled, i.e. one cycle after time_in first equals CMP.
- Periodic catch-up: if CMP+PERIOD is still in the past, hit repeats on consecutive cycles. Each repeat while pending counts as an overrun.
- Priorities within one cycle:
  - Any register write (CTRL/CMP/PERIOD) suppresses hit evaluation for that cycle. No event and no auto-reload occurs.
  - A STATUS W1C of pending in the same cycle as an event: the set wins and pending stays 1.
  - STATUS W1C of ovr plus an overrun event in the same cycle: ovr becomes 1.
- Changing irq_en affects only irq, not pending. irq is a registered output with no combinational path from the write port.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of any pending write.

Test Plan:
1. One-shot: CMP=100, CTRL=0b101, time_in counts 95..110. Required: pending=1 and irq=1 at the edge after time_in=100; state DONE; STATUS reads 0x1. W1C bit0 -> irq=0; no further events.
2. Periodic: CMP=10, PERIOD=5, CTRL=0b111, ack each event. Required: events at time_in 10, 15, 20, 25, and CMP reads 30 after the fourth event.
3. Overrun and saturation: periodic PERIOD=1, never ack, run 300 ticks with OVR_W=8. Required: ovr saturates at 255 and pending=1. W1C bit1 -> ovr=0.
4. Wrap-around: CMP=0x00000002, time_in from 0xFFFFFFFE. Required: no event at 0xFFFFFFFE..0x1; event after time_in=2. CMP=0x7FFFFFF0 while time_in=0x80000000 -> immediate event.
5. Collisions: a STATUS W1C in the same cycle as an event leaves pending=1. A CMP write in the cycle time_in==CMP yields no event that cycle. Two reads of STATUS on A and B at once return identical data; buses are 32'bz when disabled.
6. Reset: assert rst_n=0 for one edge while ARMED with pending=1 and ovr=3. Required: all registers return to reset values, irq=0, state IDLE; asynchronous rst_n pulses between edges have no effect.
